// File: rtl/temp_fan_ctrl.sv
// ADC batch sequencer, temperature conversion and three-level fan control.
// Define FAN_HYST_EN to enable hysteresis on the fan level transitions.
module temp_fan_ctrl #(
  parameter int SAMPLE_PERIOD = 1000,
  parameter int AVG_LOG2      = 2,
  parameter int T_LOW         = 25,
  parameter int T_HIGH        = 35,
  parameter int HYST          = 2,
  parameter int DUTY_LOW      = 128,
  parameter int DUTY_HIGH     = 255,
  parameter int TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] adc_value,
  input  logic        adc_done,
  output logic        conv_start,
  output logic [7:0]  temp_c,
  output logic        temp_valid,
  output logic [7:0]  duty,
  output logic [1:0]  fan_state,
  output logic        adc_timeout
);

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int AW = 12 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int N  = 1 << AVG_LOG2;

`ifdef FAN_HYST_EN
  localparam int HYST_ON = 1;
`else
  localparam int HYST_ON = 0;
`endif
  localparam int H = HYST * HYST_ON;

  localparam logic [10:0] TH_LO     = 11'(T_LOW);
  localparam logic [10:0] TH_HI     = 11'(T_HIGH);
  localparam logic [10:0] TH_LO_OFF = 11'(T_LOW - H);
  localparam logic [10:0] TH_HI_OFF = 11'(T_HIGH - H);

  localparam logic [1:0] F_OFF  = 2'd0;
  localparam logic [1:0] F_LOW  = 2'd1;
  localparam logic [1:0] F_HIGH = 2'd2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, CALC} state_t;

  state_t         state;
  logic [PW-1:0]  pcnt;
  logic           tick;
  logic [AW-1:0]  acc;
  logic [CW-1:0]  scnt;
  logic [TW-1:0]  wcnt;
  logic           req;
  logic [11:0]    avg;
  logic [12:0]    mv;
  logic [10:0]    t;
  logic [1:0]     fan_next;
  logic [7:0]     duty_next;

  assign tick       = (pcnt == PW'(SAMPLE_PERIOD - 1));
  assign conv_start = req & ~reset;

  always_ff @(posedge clk) begin
    if (reset || tick) pcnt <= '0;
    else               pcnt <= pcnt + PW'(1);
  end

  always_comb begin
    avg = 12'(acc >> AVG_LOG2);
    mv  = {1'b0, avg} + {3'b000, avg[11:2]};
    t   = mv[12:2];
  end

  // With H = 0 these rules collapse to a pure threshold map of t.
  always_comb begin
    fan_next = fan_state;
    case (fan_state)
      F_OFF: begin
        if (t >= TH_HI)      fan_next = F_HIGH;
        else if (t >= TH_LO) fan_next = F_LOW;
      end
      F_LOW: begin
        if (t >= TH_HI)          fan_next = F_HIGH;
        else if (t < TH_LO_OFF)  fan_next = F_OFF;
      end
      F_HIGH: begin
        if (t < TH_LO_OFF)       fan_next = F_OFF;
        else if (t < TH_HI_OFF)  fan_next = F_LOW;
      end
      default: fan_next = fan_state;
    endcase
  end

  always_comb begin
    duty_next = 8'd0;
    case (fan_next)
      F_LOW:   duty_next = 8'(DUTY_LOW);
      F_HIGH:  duty_next = 8'(DUTY_HIGH);
      default: duty_next = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req         <= 1'b0;
      acc         <= '0;
      scnt        <= '0;
      wcnt        <= '0;
      temp_c      <= 8'd0;
      temp_valid  <= 1'b0;
      duty        <= 8'd0;
      fan_state   <= F_OFF;
      adc_timeout <= 1'b0;
    end else begin
      temp_valid <= 1'b0;
      req        <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            state <= REQ;
            req   <= 1'b1;
          end
        end
        REQ: begin
          state <= WAIT;
          wcnt  <= '0;
        end
        WAIT: begin
          if (adc_done) begin
            acc <= acc + AW'(adc_value);
            if (scnt == CW'(N - 1)) begin
              scnt  <= '0;
              state <= CALC;
            end else begin
              scnt  <= scnt + CW'(1);
              state <= REQ;
              req   <= 1'b1;
            end
          end else if (wcnt == TW'(TIMEOUT - 1)) begin
            // Lost conversion: drop the batch and run the fan flat out.
            state       <= IDLE;
            acc         <= '0;
            scnt        <= '0;
            adc_timeout <= 1'b1;
            fan_state   <= F_HIGH;
            duty        <= 8'(DUTY_HIGH);
          end else begin
            wcnt <= wcnt + TW'(1);
          end
        end
        CALC: begin
          temp_c      <= (|t[10:8]) ? 8'hFF : t[7:0];
          temp_valid  <= 1'b1;
          fan_state   <= fan_next;
          duty        <= duty_next;
          adc_timeout <= 1'b0;
          acc         <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/temp_fan_ctrl.md
# temp_fan_ctrl

Controller that sequences the on-board ADC, averages a batch of samples, converts the average to a temperature code and sets the fan PWM duty through a three-level state machine. It sits between the ADC interface and the PWM peripheral in `top`. It feeds `temp_c` to the 7-segment display path and `duty` to the PWM generator.

## Interface
Parameters:
- `SAMPLE_PERIOD`, 1000: cycles between batch starts (≥ 2).
- `AVG_LOG2`, 2: log2 of samples per batch (0..4).
- `T_LOW`, 25: temperature code that enters LOW.
- `T_HIGH`, 35: temperature code that enters HIGH (> `T_LOW`).
- `HYST`, 2: hysteresis in temperature codes (< `T_LOW`).
- `DUTY_LOW`, 128: PWM duty in LOW.
- `DUTY_HIGH`, 255: PWM duty in HIGH and in the fail-safe state.
- `TIMEOUT`, 255: maximum number of cycles spent in WAIT.

Ports:
- `clk`  in  1: single system clock. All logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `adc_value`  in  12: conversion result. Valid only while `adc_done` = 1.
- `adc_done`  in  1: one-cycle completion strobe from the ADC.
- `conv_start`  out  1: one-cycle conversion request.
- `temp_c`  out  8: last computed temperature code.
- `temp_valid`  out  1: one-cycle pulse when `temp_c` updates.
- `duty`  out  8: PWM duty to the PWM generator.
- `fan_state`  out  2: fan level. 0 = OFF, 1 = LOW, 2 = HIGH.
- `adc_timeout`  out  1: sticky flag for a missed `adc_done`.

## Operation
- The period counter runs freely from reset. It produces `tick` once every `SAMPLE_PERIOD` cycles.
- A tick that arrives while a batch is in progress is dropped, not queued.
- Sequencer states:
  - IDLE: on `tick` go to REQ.
  - REQ: drive `conv_start` = 1, then go to WAIT.
  - WAIT: on `adc_done`, add `adc_value` to the accumulator (12+`AVG_LOG2` bits) and increment the sample count. If the count reaches 2^`AVG_LOG2`, go to CALC; otherwise go to REQ.
  - CALC: compute the results, then go to IDLE.
- `adc_done` is ignored in IDLE, REQ and CALC.
- CALC arithmetic:
  - avg = acc >> `AVG_LOG2`.
  - mv = avg + (avg >> 2), 13 bits.
  - t = mv >> 2.
  - `temp_c` = min(t, 255).
- Fan state machine, evaluated once per CALC with the new code t:
  - OFF → HIGH if t ≥ `T_HIGH`; otherwise OFF → LOW if t ≥ `T_LOW`.
  - LOW → HIGH if t ≥ `T_HIGH`; otherwise LOW → OFF if t < `T_LOW` − `HYST`.
  - HIGH → OFF if t < `T_LOW` − `HYST`; otherwise HIGH → LOW if t < `T_HIGH` − `HYST`.
  - All other cases hold the current state.
- `duty` by fan state: OFF = 0, LOW = `DUTY_LOW`, HIGH = `DUTY_HIGH`.
- Timeout handling:
  - If WAIT lasts `TIMEOUT` cycles without `adc_done`, the batch is aborted.
  - The accumulator and sample count are cleared, and the sequencer returns to IDLE.
  - `adc_timeout` is set. `fan_state` is forced to HIGH and `duty` to `DUTY_HIGH` (fail-safe).
  - `temp_c` holds its value and `temp_valid` is not pulsed.
  - `adc_timeout` clears on the next completed batch.

## Timing
- Reset values: `conv_start` 0, `temp_c` 0, `temp_valid` 0, `duty` 0, `fan_state` 0 (OFF), `adc_timeout` 0. Sequencer in IDLE, period counter at 0, accumulator at 0.
- Reset asserted mid-batch aborts the batch on the next edge. No `conv_start` is issued while `reset` = 1.
- `tick` in cycle t → `conv_start` high in cycle t+1 only.
- `adc_done` in cycle n with more samples pending → `conv_start` high in cycle n+1.
- Last `adc_done` in cycle n → CALC in cycle n+1 → new `temp_c`, `duty` and `fan_state` with `temp_valid` = 1 in cycle n+2.
- `adc_done` in the same cycle that the timeout expires counts as a sample. Timeout does not fire.
- Minimum batch length is 2^`AVG_LOG2`·2 + 1 cycles, which with defaults is 9, well under `SAMPLE_PERIOD`.

## Configuration
- `FAN_HYST_EN` defined: the hysteresis transitions are exactly as in Operation.
- `FAN_HYST_EN` undefined: `HYST` is treated as 0. The fan state is then purely a function of t:
  - t ≥ `T_HIGH` → HIGH.
  - t ≥ `T_LOW` → LOW.
  - Otherwise OFF.
- Sequencing, arithmetic and timeout behaviour are identical in both builds.

## Test plan
- Reset, then bench ADC answers each `conv_start` after 5 cycles with `adc_value` = 819 → four `conv_start` pulses per batch, `temp_c` = 255, `fan_state` = HIGH, `duty` = 255, one `temp_valid` pulse.
- `adc_value` = 100 from OFF → t = 31, `fan_state` LOW, `duty` 128. Then `adc_value` = 120 → t = 37, HIGH.
- Hysteresis, with `FAN_HYST_EN`: from HIGH, `adc_value` = 108 (t = 33) → stays HIGH. Then 104 (t = 32) → LOW. Without the macro, 108 → LOW.
- `adc_value` = 64 (t = 20) from LOW → OFF, `duty` 0. With `FAN_HYST_EN`, 76 (t = 23) from LOW → stays LOW.
- Bench withholds `adc_done` → after 255 WAIT cycles, `adc_timeout` = 1, `duty` = 255, no `temp_valid`. The next good batch clears `adc_timeout`.
- `reset` asserted between the second and third `adc_done` → all outputs at reset values next cycle. The next batch averages only fresh samples.
